// File: rtl/shift_sequencer32_pkg.sv
// Shared types and constants for the multi-cycle shift sequencer.
package shift_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    localparam logic SHDIR_RIGHT = 1'b0;
    localparam logic SHDIR_LEFT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_sequencer32_if.sv
// Request/result bundle between the shift sequencer and its requester.
interface shift_sequencer32_if import shift_pkg::*; ();

    logic               start;
    logic [DATA_W-1:0]  in;
    logic [SHAMT_W-1:0] shamt;
    logic               shiftdir;
    logic               shifta;
    logic [DATA_W-1:0]  out;
    logic               busy;
    logic               done;

    modport master (
        output start, in, shamt, shiftdir, shifta,
        input  out, busy, done
    );

    modport slave (
        input  start, in, shamt, shiftdir, shifta,
        output out, busy, done
    );

endinterface

// File: rtl/shift_sequencer32_shifter32b1.sv
// Single-bit shift stage: passes the operand through, or shifts it by one
// position left (zero fill) or right (zero or sign fill).
module shifter32b1 import shift_pkg::*; (
    input  logic [DATA_W-1:0] in,
    input  logic              shiftdir,
    input  logic              shift,
    input  logic              shifta,
    output logic [DATA_W-1:0] out
);

    logic fill;

    assign fill = shifta & in[DATA_W-1];

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_bit
            logic left_bit;
            logic right_bit;

            if (gi == 0) begin : g_lsb
                assign left_bit = 1'b0;
            end else begin : g_lmid
                assign left_bit = in[gi-1];
            end

            if (gi == DATA_W - 1) begin : g_msb
                assign right_bit = fill;
            end else begin : g_rmid
                assign right_bit = in[gi+1];
            end

            assign out[gi] = !shift ? in[gi]
                           : (shiftdir == SHDIR_LEFT) ? left_bit : right_bit;
        end
    endgenerate

endmodule

// File: rtl/shift_sequencer32.sv
// Sequences a one-bit shift stage once per cycle until the captured shift
// amount is used up, with a start/busy/done handshake.
module shift_sequencer32 import shift_pkg::*; (
    input  logic                clk,
    input  logic                rstn,
    shift_sequencer32_if.slave  bus
);

    state_t             state_reg, state_next;
    logic [SHAMT_W-1:0] cnt_reg, cnt_next;
    logic [DATA_W-1:0]  out_reg, out_next;
    logic               dir_reg, dir_next;
    logic               arith_reg, arith_next;
    logic [DATA_W-1:0]  step_out;

    shifter32b1 u_step (
        .in       (out_reg),
        .shiftdir (dir_reg),
        .shift    (1'b1),
        .shifta   (arith_reg),
        .out      (step_out)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            out_reg   <= '0;
            dir_reg   <= SHDIR_RIGHT;
            arith_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            out_reg   <= out_next;
            dir_reg   <= dir_next;
            arith_reg <= arith_next;
        end
    end

    // DONE accepts a new start just like IDLE so back-to-back ops need no bubble.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        out_next   = out_reg;
        dir_next   = dir_reg;
        arith_next = arith_reg;
        unique case (state_reg)
            IDLE, DONE: begin
                if (bus.start) begin
                    out_next   = bus.in;
                    cnt_next   = bus.shamt;
                    dir_next   = bus.shiftdir;
                    arith_next = bus.shifta;
                    state_next = (bus.shamt == '0) ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                out_next = step_out;
                cnt_next = cnt_reg - 5'd1;
                if (cnt_reg == 5'd1) begin
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.out  = out_reg;
    assign bus.busy = (state_reg == RUN);
    assign bus.done = (state_reg == DONE);

endmodule
